// File: rtl/serializer_pkg.sv
// Shared types and sizing for the bit serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH = 8;
  localparam int SER_CNT_W = $clog2(SER_WIDTH);

  // Bit-counter width for an arbitrary word width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Word holding register with MSB-first bit-select mux.
module ser_shift_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    sel,
  output logic             bit_out
);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst)       shreg <= '0;
    else if (load) shreg <= data;
  end

  // sel counts bits already sent, so bit 0 of the stream is the MSB.
  assign idx     = CW'(WIDTH - 1) - sel;
  assign bit_out = shreg[idx];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end, MSB first, gapless back-to-back words.
// Define SER_PARITY_EN to append one even-parity bit after every word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  ser_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load, accept, out_nx, vld_nx, shift_bit, last;
`ifdef SER_PARITY_EN
  logic          par;
`endif

  ser_shift_reg #(.WIDTH(WIDTH), .CW(CW)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data_in),
    .sel     (cnt),
    .bit_out (shift_bit)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    accept    = 1'b0;
    out_nx    = 1'b0;
    vld_nx    = 1'b0;
    ready_out = 1'b0;
    case (state)
      IDLE: ready_out = 1'b1;
      SHIFT: begin
        out_nx = shift_bit;
        vld_nx = 1'b1;
        if (last) begin
          cnt_nx = '0;
`ifdef SER_PARITY_EN
          state_nx = PARITY;
`else
          ready_out = 1'b1;
          state_nx  = IDLE;
`endif
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ready_out = 1'b1;
        out_nx    = par;
        vld_nx    = 1'b1;
        state_nx  = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
    // A word taken on the final bit cycle streams with no bubble.
    accept = valid_in && ready_out;
    if (accept) begin
      load     = 1'b1;
      state_nx = SHIFT;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ser_out   <= out_nx;
      ser_valid <= vld_nx;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         par <= 1'b0;
    else if (accept) par <= ^data_in;
  end
`endif

  // busy tracks the bit on the wire, so it coincides with ser_valid.
  assign busy = ser_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8).
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, ser_out, ser_valid, busy;
  int         n_chk = 0;
  int         n_fail = 0;

  bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one 8-bit word from IDLE and check the emitted bits.
  task automatic send_word(input string tag, input logic [7:0] w);
    data_in  = w;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk({tag, "_lat_vld"}, ser_valid, 1'b0);
    chk({tag, "_lat_rdy"}, ready_out, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step();
      chk({tag, "_bit"}, ser_out, w[i]);
      chk({tag, "_vld"}, ser_valid, 1'b1);
      chk({tag, "_busy"}, busy, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] pat;
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hFF;

    // reset holds off accepts
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_vld", ser_valid, 1'b0);
      chk("rst_out", ser_out, 1'b0);
      chk("rst_rdy", ready_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    step();
    chk("idle_vld", ser_valid, 1'b0);
    chk("idle_rdy", ready_out, 1'b1);

`ifndef SER_PARITY_EN
    send_word("b5", 8'hB5);
    chk("b5_end_rdy", ready_out, 1'b1);
    step();
    chk("b5_tail_vld", ser_valid, 1'b0);
    chk("b5_tail_out", ser_out, 1'b0);
    chk("b5_tail_busy", busy, 1'b0);

    // back-to-back F0 then 0F
    pat      = 16'b1111000000001111;
    data_in  = 8'hF0;
    valid_in = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("b2b_rdy", ready_out, (k == 0 || k == 8 || k == 16));
      if (k == 1) data_in = 8'h0F;
      if (k == 9) valid_in = 1'b0;
      step();
      if (k == 0) chk("b2b_lat_vld", ser_valid, 1'b0);
      else begin
        chk("b2b_bit", ser_out, pat[16-k]);
        chk("b2b_vld", ser_valid, 1'b1);
      end
    end
    step();
    chk("b2b_tail_vld", ser_valid, 1'b0);
`else
    // parity: B5 has five ones -> parity 1; 03 has two -> parity 0
    send_word("pb5", 8'hB5);
    chk("pb5_par_rdy", ready_out, 1'b1);
    step();
    chk("pb5_par", ser_out, 1'b1);
    chk("pb5_par_vld", ser_valid, 1'b1);
    chk("pb5_post_rdy", ready_out, 1'b1);
    step();
    chk("pb5_tail_vld", ser_valid, 1'b0);

    send_word("p03", 8'h03);
    chk("p03_par_rdy", ready_out, 1'b1);
    step();
    chk("p03_par", ser_out, 1'b0);
    chk("p03_par_vld", ser_valid, 1'b1);
    step();
    chk("p03_tail_vld", ser_valid, 1'b0);
`endif

    // reset mid-word
    data_in  = 8'hFF;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_bit", ser_out, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", ser_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdy", ready_out, 1'b1);
    chk("mid_rst_out", ser_out, 1'b0);
    step();
    chk("mid_idle_vld", ser_valid, 1'b0);
    send_word("w80", 8'h80);
`ifndef SER_PARITY_EN
    step();
    chk("w80_tail_vld", ser_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
